// File: rtl/capture_sequencer.sv
// Acquisition control FSM: loads and arms the trigger, fills pre-trigger samples,
// waits for a run edge, counts post-trigger samples and drives the buffer write port.
// Optional macro CAPTURE_TIMEOUT_EN adds a WAIT_TRIG timeout that forces a trigger.
module capture_sequencer #(
  parameter int ADDR_WIDTH = 12
`ifdef CAPTURE_TIMEOUT_EN
  , parameter int TO_WIDTH = 32
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic                  valid,
  input  logic                  run,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [TO_WIDTH-1:0]   timeout_cycles,
  output logic                  timed_out,
`endif
  output logic                  load_trigs,
  output logic                  arm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ARM       = 3'd2,
    S_PREFILL   = 3'd3,
    S_WAIT_TRIG = 3'd4,
    S_POST      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] cnt_inc, addr_inc;
  logic                  run_q, load_q, arm_q, busy_q, done_q;
  logic                  capturing, start_ok, run_edge, force_trig, trig_hit;

  assign capturing = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign run_edge  = run && !run_q;
  assign cnt_inc   = count_q + ADDR_WIDTH'(1);
  assign addr_inc  = wr_addr_q + ADDR_WIDTH'(1);
  assign trig_hit  = (state_q == S_WAIT_TRIG) && (run_edge || force_trig);

`ifdef CAPTURE_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                timed_out_q, timed_out_d;

  assign force_trig = (timeout_cycles != '0) && (to_cnt_q == timeout_cycles);
  assign timed_out  = timed_out_q;

  always_comb begin
    to_cnt_d    = (state_q == S_WAIT_TRIG) ? to_cnt_q + TO_WIDTH'(1) : '0;
    timed_out_d = timed_out_q;
    if (!abort) begin
      if (start_ok)
        timed_out_d = 1'b0;
      else if (trig_hit && !run_edge)
        timed_out_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`else
  assign force_trig = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    pre_d       = pre_q;
    post_d      = post_q;

    case (state_q)
      S_IDLE: begin
        count_d   = '0;
        wr_addr_d = '0;
      end
      S_LOAD:  state_d = S_ARM;
      S_ARM:   state_d = (pre_q == '0) ? S_WAIT_TRIG : S_PREFILL;
      S_PREFILL: begin
        if (valid) begin
          wr_addr_d = addr_inc;
          count_d   = cnt_inc;
          if (cnt_inc == pre_q)
            state_d = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
        if (valid)
          wr_addr_d = addr_inc;
        if (trig_hit) begin
          trig_addr_d = wr_addr_q;
          count_d     = '0;
          // With no post samples the trigger sample is the last one: wr_addr parks on it.
          if (post_q == '0) begin
            state_d   = S_DONE;
            wr_addr_d = wr_addr_q;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (valid) begin
          count_d = cnt_inc;
          if (cnt_inc == post_q)
            state_d = S_DONE;
          else
            wr_addr_d = addr_inc;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // A new acquisition restarts the buffer at address 0 with freshly sampled limits.
    if (start_ok) begin
      state_d   = S_LOAD;
      count_d   = '0;
      wr_addr_d = '0;
      pre_d     = pre_count;
      post_d    = post_count;
    end

    if (abort) begin
      state_d     = S_IDLE;
      count_d     = '0;
      wr_addr_d   = '0;
      trig_addr_d = trig_addr_q;
      pre_d       = pre_q;
      post_d      = post_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      run_q       <= 1'b0;
      load_q      <= 1'b0;
      arm_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      run_q       <= run;
      load_q      <= (state_d == S_LOAD);
      arm_q       <= (state_d == S_ARM);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_PREFILL) ||
                     (state_d == S_WAIT_TRIG) || (state_d == S_POST);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign wr_en      = valid && capturing;
  assign load_trigs = load_q;
  assign arm        = arm_q;
  assign wr_addr    = wr_addr_q;
  assign trig_addr  = trig_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer (16-entry buffer): a planner derives the expected
// pulses, write addresses and final status from per-cycle valid/run tables.
module tb_capture_sequencer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NMAX  = 256;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, valid = 1'b0, run = 1'b0;
  logic [AW-1:0] pre_count = '0, post_count = '0;
  logic          load_trigs, arm, wr_en, busy, done;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [2:0]    state;

  capture_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .pre_count(pre_count), .post_count(post_count), .valid(valid), .run(run),
    .load_trigs(load_trigs), .arm(arm), .wr_en(wr_en), .wr_addr(wr_addr),
    .trig_addr(trig_addr), .busy(busy), .done(done), .state(state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 0 load_trigs, 1 arm, 2 write (a=addr), 3 done rise (a=trig_addr, b=wr_addr)
  typedef struct { int kind; int c; int a; int b; } evt_t;
  typedef struct { int c; int st; int bsy; int dn; int wa; int ta; } stat_t;
  evt_t  evq[$];
  stat_t stq[$];

  int checks = 0, errors = 0;
  bit finishing = 1'b0, mon_done = 1'b0, done_prev = 1'b0;
  bit va[NMAX];
  bit ra[NMAX];
  int last_trig = 0;

  task automatic take(input int kind, input int a, input int b);
    evt_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d a=%0d b=%0d, required no event", kind, cyc, a, b);
      return;
    end
    e = evq.pop_front();
    if (e.kind != kind || e.c != cyc || e.a != a || e.b != b) begin
      errors++;
      $display("FAIL event got kind=%0d cyc=%0d a=%0d b=%0d required kind=%0d cyc=%0d a=%0d b=%0d",
               kind, cyc, a, b, e.kind, e.c, e.a, e.b);
    end
  endtask

  always @(negedge clock) begin
    stat_t s;
    if (reset_n) begin
      if (load_trigs) take(0, 0, 0);
      if (arm) take(1, 0, 0);
      if (wr_en) take(2, int'(wr_addr), 0);
      if (done && !done_prev) take(3, int'(trig_addr), int'(wr_addr));
    end
    while (stq.size() > 0 && stq[0].c <= cyc) begin
      s = stq.pop_front();
      checks++;
      if (s.c != cyc || int'(state) != s.st || int'(busy) != s.bsy || int'(done) != s.dn ||
          int'(wr_addr) != s.wa || int'(trig_addr) != s.ta || load_trigs || arm || wr_en) begin
        errors++;
        $display("FAIL status cyc=%0d got st=%0d busy=%0d done=%0d wa=%0d ta=%0d lt=%0d arm=%0d we=%0d required cyc=%0d st=%0d busy=%0d done=%0d wa=%0d ta=%0d lt=0 arm=0 we=0",
                 cyc, state, busy, done, wr_addr, trig_addr, load_trigs, arm, wr_en,
                 s.c, s.st, s.bsy, s.dn, s.wa, s.ta);
      end
    end
    done_prev <= done;
    if (finishing && !mon_done) begin
      checks++;
      if (evq.size() != 0 || stq.size() != 0) begin
        errors++;
        $display("FAIL leftover got events=%0d status=%0d required 0 and 0", evq.size(), stq.size());
      end
      mon_done <= 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_evt(input int kind, input int c, input int a, input int b);
    evq.push_back('{kind, c, a, b});
  endtask

  task automatic push_stat(input int c, input int st, input int bsy, input int dn, input int wa, input int ta);
    stq.push_back('{c, st, bsy, dn, wa, ta});
  endtask

  // Relative cycle 0 carries start; 1 LOAD, 2 ARM, capture from 3. Returns the last
  // capture cycle, or -1 if the tables never complete an acquisition.
  function automatic int plan(input int pre, input int post, output int t, output int trig, output int fin);
    int w, nv, e;
    t = -1; trig = 0; fin = 0; e = -1; w = 3;
    if (pre > 0) begin
      nv = 0; w = -1;
      for (int k = 3; k < NMAX; k++)
        if (va[k]) begin nv++; if (nv == pre) begin w = k + 1; break; end end
      if (w < 0) return -1;
    end
    for (int k = w; k < NMAX; k++)
      if (ra[k] && !ra[k-1]) begin t = k; break; end
    if (t < 0) return -1;
    if (post == 0) e = t;
    else begin
      nv = 0;
      for (int k = t + 1; k < NMAX; k++)
        if (va[k]) begin nv++; if (nv == post) begin e = k; break; end end
    end
    if (e < 0 || e + 4 >= NMAX) return -1;
    nv = 0;
    for (int k = 3; k < t; k++) nv += int'(va[k]);
    trig = nv % DEPTH;
    if (post == 0) fin = trig;
    else begin
      nv = 0;
      for (int k = 3; k <= e; k++) nv += int'(va[k]);
      fin = (nv - 1) % DEPTH;
    end
    return e;
  endfunction

  function automatic bit keep(input int k, input int ab_at, input bit use_rst);
    if (ab_at < 0) return 1'b1;
    return use_rst ? (k < ab_at) : (k <= ab_at);
  endfunction

  // ab_at >= 0: abort (or async reset when use_rst) in that relative cycle.
  task automatic drive_acq(input int pre, input int post, input int ab_at, input bit use_rst);
    int t, trig, fin, e, c0, idx, last;
    e = plan(pre, post, t, trig, fin);
    next_cycle();
    c0 = cyc;
    if (keep(1, ab_at, use_rst)) push_evt(0, c0 + 1, 0, 0);
    if (keep(2, ab_at, use_rst)) push_evt(1, c0 + 2, 0, 0);
    idx = 0;
    for (int k = 3; k <= e; k++)
      if (va[k]) begin
        if (keep(k, ab_at, use_rst)) push_evt(2, c0 + k, idx % DEPTH, 0);
        idx++;
      end
    if (keep(e + 1, ab_at, use_rst)) begin
      push_evt(3, c0 + e + 1, trig, fin);
      push_stat(c0 + e + 1, 6, 0, 1, fin, trig);
    end
    last = (ab_at >= 0) ? ab_at : e + 3;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) next_cycle();
      valid      = va[k];
      run        = ra[k];
      pre_count  = (k == 0) ? AW'(pre)  : AW'($urandom_range(15, 0));
      post_count = (k == 0) ? AW'(post) : AW'($urandom_range(15, 0));
      start      = (k == 0) || (k <= e && $urandom_range(7, 0) == 0);
      abort      = 1'b0;
      if (k == ab_at) begin
        if (use_rst) begin
          #2;
          reset_n = 1'b0;
          push_stat(c0 + k, 0, 0, 0, 0, 0);
        end else begin
          abort = 1'b1;
          start = ($urandom_range(1, 0) == 1);
        end
      end
    end
    if (ab_at >= 0 && !use_rst) begin
      next_cycle();
      start = 1'b0; abort = 1'b0; valid = ($urandom_range(1, 0) == 1);
      if (t < ab_at) last_trig = trig;
      push_stat(cyc, 0, 0, 0, 0, last_trig);
    end else if (use_rst) begin
      next_cycle();
      next_cycle();
      reset_n = 1'b1; start = 1'b0; abort = 1'b0;
      last_trig = 0;
    end else begin
      last_trig = trig;
      start = 1'b0;
    end
  endtask

  task automatic gen_random();
    int pv;
    bit r;
    pv = $urandom_range(100, 40);
    r  = run;
    for (int k = 0; k < NMAX; k++) begin
      va[k] = ($urandom_range(99, 0) < pv);
      if ($urandom_range(5, 0) == 0) r = ~r;
      ra[k] = r;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no completion, required completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre, post, e, t, trig, fin, ab, sel, tries;
    bit rs;

    // Reset with valid toggling: everything idle.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      valid = ~valid;
      push_stat(cyc, 0, 0, 0, 0, 0);
    end
    reset_n = 1'b1;
    valid = 1'b0;
    next_cycle();

    // pre=4, post=3, run rises 10 cycles into WAIT_TRIG.
    for (int k = 0; k < NMAX; k++) begin va[k] = 1'b1; ra[k] = (k >= 17); end
    drive_acq(4, 3, -1, 1'b0);

    // pre=0, post=0, run already high at ARM; accepted only on a fresh rise.
    for (int k = 0; k < NMAX; k++) begin va[k] = 1'b1; ra[k] = (k < 8) || (k >= 12); end
    drive_acq(0, 0, -1, 1'b0);

    // pre=2, post=5, trigger after 20 samples: wraps the 16-entry buffer.
    for (int k = 0; k < NMAX; k++) begin va[k] = 1'b1; ra[k] = (k >= 23); end
    drive_acq(2, 5, -1, 1'b0);

    // Abort together with start while in POST.
    for (int k = 0; k < NMAX; k++) begin va[k] = 1'b1; ra[k] = (k >= 17); end
    drive_acq(4, 3, 19, 1'b0);

    for (int n = 0; n < 40; n++) begin
      pre  = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(15, 1));
      post = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(15, 1));
      e = -1;
      tries = 0;
      while (e < 0 && tries < 100) begin
        gen_random();
        e = plan(pre, post, t, trig, fin);
        tries++;
      end
      if (e >= 0) begin
        sel = $urandom_range(9, 0);
        ab = -1;
        rs = 1'b0;
        if (sel < 2) ab = $urandom_range(e + 2, 0);
        else if (sel == 2) begin ab = $urandom_range(e + 2, 0); rs = 1'b1; end
        drive_acq(pre, post, ab, rs);
      end
    end

    next_cycle();
    finishing = 1'b1;
    for (int k = 0; k < 3; k++) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Control FSM for one acquisition on the logic analyzer.
- Sequences the basic trigger unit: one-cycle load_trigs pulse, then one-cycle arm pulse.
- Enforces a pre-trigger fill, watches the trigger's run output, counts post-trigger samples, and drives the write side of the circular sample buffer.
- Sits between the host command/register block, trigger_basic and the sample RAM.

Parameters:
- ADDR_WIDTH, 12, sample-buffer address width; depth = 2^ADDR_WIDTH.
- TO_WIDTH, 32, width of the timeout counter (used only with the optional feature).

Ports:
- clock  in  1  sample/system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins an acquisition.
- abort  in  1  one-cycle pulse; cancels the acquisition.
- pre_count  in  ADDR_WIDTH  samples to capture before a trigger is accepted.
- post_count  in  ADDR_WIDTH  samples to capture after the trigger.
- valid  in  1  sample strobe, same as the trigger's valid.
- run  in  1  trigger output; level, goes high on trigger.
- load_trigs  out  1  one-cycle pulse to latch the trigger masks.
- arm  out  1  one-cycle pulse to arm the trigger.
- wr_en  out  1  buffer write enable (= valid while capturing).
- wr_addr  out  ADDR_WIDTH  buffer write address.
- trig_addr  out  ADDR_WIDTH  buffer address at which the trigger was accepted.
- busy  out  1  high from LOAD through POST.
- done  out  1  high in DONE.
- state  out  3  current state encoding, for status readback.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset (asynchronous assert) puts the FSM in IDLE and clears every output, wr_addr, trig_addr and all counters to 0.
- Outputs:
  - All outputs are registered except wr_en, which equals valid AND (state in PREFILL, WAIT_TRIG or POST).
- State encoding: IDLE=0, LOAD=1, ARM=2, PREFILL=3, WAIT_TRIG=4, POST=5, DONE=6.
- IDLE:
  - start moves to LOAD.
  - wr_addr and the sample counter clear to 0.
- LOAD: load_trigs=1 for exactly this cycle; next state ARM.
- ARM:
  - arm=1 for exactly this cycle.
  - Next state is PREFILL, or WAIT_TRIG if pre_count==0.
- PREFILL:
  - Each valid writes one sample: wr_addr+1 (mod 2^ADDR_WIDTH) and count+1.
  - When count reaches pre_count on a valid cycle, go to WAIT_TRIG next cycle.
  - run is ignored in this state.
- WAIT_TRIG:
  - Writes continue; wr_addr wraps freely.
  - A rising edge of run (run & !run_q) captures trig_addr = wr_addr of that cycle and clears count.
  - Next state is POST, or DONE if post_count==0.
  - If run is already high on entry, it is not a rising edge; wait for a new one.
- POST:
  - Each valid writes and increments count.
  - When count reaches post_count, go to DONE.
  - The last write occurs in the final POST cycle.
- DONE:
  - done=1, busy=0, no writes.
  - start begins a new acquisition (moves to LOAD, done clears).
  - abort moves to IDLE.
- abort:
  - From any state, the next state is IDLE; load_trigs, arm and done deassert.
  - trig_addr holds its last value.
- Command collisions:
  - start and abort in the same cycle: abort wins.
  - start while busy is ignored.
- Count limits:
  - pre_count and post_count are sampled into registers on the start cycle.
  - Later changes have no effect until the next start.
  - pre_count + post_count greater than the depth is legal; the oldest samples are overwritten.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - Adds input timeout_cycles[TO_WIDTH-1:0] and output timed_out (registered, reset 0).
  - In WAIT_TRIG, a counter increments every clock.
  - If the counter reaches timeout_cycles (nonzero) before a run edge, the FSM forces a trigger: trig_addr=wr_addr, timed_out=1, then POST.
  - timed_out clears on the next start.
  - timeout_cycles==0 disables the timeout.
- Not defined: no extra ports; WAIT_TRIG waits indefinitely.

Test Plan:
- Reset with valid toggling → all outputs 0; state=0; no wr_en.
- start with pre=4, post=3, valid every cycle, run rises 10 cycles after entering WAIT_TRIG:
  - load_trigs is high exactly 1 cycle, arm exactly 1 cycle after it.
  - 4 writes in PREFILL; trig_addr=14.
  - 3 POST writes; done=1; final wr_addr=17.
- pre=0, post=0, run already high at ARM: FSM skips PREFILL; no trigger until run falls and rises again; then DONE directly with no POST writes.
- ADDR_WIDTH=4, pre=2, post=5, trigger after 20 samples → wr_addr wraps through 0; trig_addr=20 mod 16=4; done with wr_addr=9.
- abort in POST with a simultaneous start → IDLE next cycle; done=0, busy=0; wr_en low; trig_addr retained.
- CAPTURE_TIMEOUT_EN, timeout_cycles=8, run held 0 → forced trigger 8 cycles after entering WAIT_TRIG; timed_out=1; POST completes; the next start clears timed_out.
